multiplier: RTL and testbench
=============================

MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port n_rst, input, 1 bit: synchronous, active-high reset (1 = reset at next rising clk edge).
REQ-003 SHALL have port row_select, input, 4 bits: weight row 0-9, captured when begin_mult is accepted.
REQ-004 SHALL have port begin_mult, input, 1 bit: start request, sampled in IDLE.
REQ-005 SHALL have ports pixel_value_1 and pixel_value_2, inputs, 8 bits each: unsigned pixel data for pixel_address_1 and pixel_address_2.
REQ-006 SHALL have ports weight_value_1 and weight_value_2, inputs, 16 bits each: unsigned weight data for weight_address_1 and weight_address_2.
REQ-007 SHALL have ports pixel_address_1 and pixel_address_2, outputs, 10 bits each: pixel memory addresses, 0-783.
REQ-008 SHALL have ports weight_address_1 and weight_address_2, outputs, 13 bits each: weight memory addresses, 0-7839.
REQ-009 SHALL have port done_row, output, 1 bit: one-cycle pulse when row_result and overflow are valid.
REQ-010 SHALL have port row_result, output, 16 bits: dot-product result, saturated.
REQ-011 SHALL have port overflow, output, 1 bit: set when the true sum exceeds 65535.
REQ-012 SHALL have port w_result_ena, output, 1 bit: result write strobe, identical timing to done_row.

Function
REQ-013 SHALL compute one row of a 784-input dot product: sum over i=0..783 of pixel[i]*weight[row*784+i], all operands unsigned.
REQ-014 SHALL process two terms per cycle, so one row takes 392 MAC cycles.
REQ-015 SHALL use a three-state FSM: IDLE, MAC, DONE.
REQ-016 IDLE: on a clk edge with begin_mult=1 and row_select<=9, SHALL latch row_select, clear the accumulator and counter k, clear overflow, and go to MAC.
REQ-017 IDLE: begin_mult with row_select>9 SHALL be ignored.
REQ-018 MAC: addresses SHALL be combinational from registered state: pixel_address_1=2k, pixel_address_2=2k+1, weight_address_1=row*784+2k, weight_address_2=row*784+2k+1.
REQ-019 Memory reads are combinational: value inputs SHALL correspond to the addresses driven in the same cycle and SHALL be sampled at the end of that cycle.
REQ-020 MAC: each edge SHALL add pixel_value_1*weight_value_1 + pixel_value_2*weight_value_2 to an accumulator at least 35 bits wide (no internal wrap); k SHALL increment 0..391.
REQ-021 MAC: after the edge that accumulates k=391, SHALL go to DONE.
REQ-022 On the MAC-to-DONE transition, row_result SHALL register min(acc, 16'hFFFF) and overflow SHALL register (acc>65535).
REQ-023 DONE: done_row=1 and w_result_ena=1 for exactly one cycle, then SHALL return to IDLE.
REQ-024 done_row SHALL therefore assert in the 393rd cycle after the accepting begin edge.
REQ-025 row_result and overflow SHALL hold until the next accepted begin_mult clears overflow or reset occurs; row_result holds until the next DONE.
REQ-026 begin_mult SHALL be ignored in MAC and DONE; row_select changes after capture SHALL have no effect.
REQ-027 In IDLE and DONE, address outputs SHALL be pixel 0/1 and weight row*784 / row*784+1 of the last captured row.

Reset
REQ-028 n_rst=1 at a clk edge SHALL force IDLE, row=0, k=0, accumulator=0, row_result=0, overflow=0, done_row=0, w_result_ena=0, all addresses 0/1 per REQ-027, including mid-MAC; no done_row pulse follows an aborted row.

Verification
REQ-029 All pixels=1, all weights=1, row_select=0, begin pulse -> done_row 393 cycles later, row_result=784, overflow=0, w_result_ena pulses with done_row.
REQ-030 Pixels=1, weight_value_1=1, weight_value_2=0, row_select=1 -> row_result=392, overflow=0; weight addresses in range 784-1567.
REQ-031 Pixels=1, weight_value_1=168, weight_value_2=0 -> true sum 65856, overflow=1, row_result=16'hFFFF.
REQ-032 Pixels=255, weights=65535, row_select=9 -> overflow=1, row_result=16'hFFFF; final weight_address_2=7839, no accumulator wrap.
REQ-033 n_rst asserted after 100 MAC cycles -> all outputs zero, no done_row; fresh begin then yields the correct result.
REQ-034 begin_mult re-pulsed mid-row and begin_mult with row_select=12 in IDLE -> both ignored, no extra done_row.

Source files
------------

// File: rtl/multiplier.sv
// Row dot-product engine: accumulates 784 pixel*weight terms, two per cycle,
// and reports a saturated 16-bit result plus an overflow flag.
module multiplier (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [3:0]  row_select,
    input  logic        begin_mult,
    input  logic [7:0]  pixel_value_1,
    input  logic [7:0]  pixel_value_2,
    input  logic [15:0] weight_value_1,
    input  logic [15:0] weight_value_2,
    output logic [9:0]  pixel_address_1,
    output logic [9:0]  pixel_address_2,
    output logic [12:0] weight_address_1,
    output logic [12:0] weight_address_2,
    output logic        done_row,
    output logic [15:0] row_result,
    output logic        overflow,
    output logic        w_result_ena
);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    localparam logic [8:0]  LAST_K   = 9'd391;
    localparam logic [12:0] ROW_SIZE = 13'd784;

    state_t      state, state_next;
    logic [3:0]  row;
    logic [8:0]  k;
    logic [35:0] acc;
    logic [35:0] acc_sum;
    logic [24:0] term;
    logic        start;
    logic        last;
    logic [8:0]  k_eff;
    logic [9:0]  pix_base;
    logic [12:0] weight_base;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        start      = (state == IDLE) && begin_mult && (row_select <= 4'd9);
        last       = (state == MAC) && (k == LAST_K);
        term       = 25'(pixel_value_1) * 25'(weight_value_1)
                   + 25'(pixel_value_2) * 25'(weight_value_2);
        acc_sum    = acc + 36'(term);
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state      <= IDLE;
            row        <= '0;
            k          <= '0;
            acc        <= '0;
            row_result <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                row      <= row_select;
                k        <= '0;
                acc      <= '0;
                overflow <= 1'b0;
            end else if (state == MAC) begin
                acc <= acc_sum;
                k   <= k + 9'd1;
                if (last) begin
                    row_result <= (acc_sum > 36'd65535) ? 16'hFFFF : acc_sum[15:0];
                    overflow   <= (acc_sum > 36'd65535);
                end
            end
        end
    end

    // Outside MAC the addresses rest on the first pair of the captured row.
    always_comb begin
        k_eff            = (state == MAC) ? k : 9'd0;
        pix_base         = {k_eff, 1'b0};
        weight_base      = 13'(row) * ROW_SIZE;
        pixel_address_1  = pix_base;
        pixel_address_2  = pix_base | 10'd1;
        weight_address_1 = weight_base + 13'(pix_base);
        weight_address_2 = weight_address_1 + 13'd1;
    end

    assign done_row     = (state == DONE);
    assign w_result_ena = (state == DONE);

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: table-driven rows over constant memories,
// an address-dependent memory row, plus reset-abort and ignored-begin sequences.
module tb_multiplier;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [3:0]  row_select;
    logic        begin_mult;
    logic [7:0]  pixel_value_1, pixel_value_2;
    logic [15:0] weight_value_1, weight_value_2;
    logic [9:0]  pixel_address_1, pixel_address_2;
    logic [12:0] weight_address_1, weight_address_2;
    logic        done_row, overflow, w_result_ena;
    logic [15:0] row_result;

    int checks = 0;
    int errors = 0;

    // Memory model: constant values, or values derived from the address.
    bit          addr_mode = 1'b0;
    logic [7:0]  p1c, p2c;
    logic [15:0] w1c, w2c;

    always #5 clk = ~clk;

    always_comb begin
        if (addr_mode) begin
            pixel_value_1  = 8'(pixel_address_1 % 10'd3);
            pixel_value_2  = 8'(pixel_address_2 % 10'd3);
            weight_value_1 = 16'(weight_address_1 % 13'd41);
            weight_value_2 = 16'(weight_address_2 % 13'd41);
        end else begin
            pixel_value_1  = p1c;
            pixel_value_2  = p2c;
            weight_value_1 = w1c;
            weight_value_2 = w2c;
        end
    end

    multiplier dut (
        .clk(clk), .n_rst(n_rst), .row_select(row_select), .begin_mult(begin_mult),
        .pixel_value_1(pixel_value_1), .pixel_value_2(pixel_value_2),
        .weight_value_1(weight_value_1), .weight_value_2(weight_value_2),
        .pixel_address_1(pixel_address_1), .pixel_address_2(pixel_address_2),
        .weight_address_1(weight_address_1), .weight_address_2(weight_address_2),
        .done_row(done_row), .row_result(row_result), .overflow(overflow),
        .w_result_ena(w_result_ena)
    );

    typedef struct {
        logic [3:0]  row;
        logic [7:0]  p1, p2;
        logic [15:0] w1, w2;
        logic [15:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one row from IDLE; optionally re-pulses begin_mult mid-row with another row.
    task automatic run_row(input logic [3:0] r, input logic [15:0] exp_res,
                           input logic exp_ovf, input bit repulse, input string tag);
        int          cycles;
        bit          seen;
        logic [12:0] wmin, wmax;
        logic [9:0]  pmax;
        logic [12:0] base;
        base = 13'(r) * 13'd784;
        wmin = '1; wmax = '0; pmax = '0;
        seen = 1'b0;
        row_select = r;
        begin_mult = 1'b1;
        step();
        begin_mult = 1'b0;
        row_select = 4'd15;
        check({tag, " ovf_cleared"}, 64'(overflow), 64'd0);
        cycles = 0;
        while (cycles < 500) begin
            if (done_row) begin
                seen = 1'b1;
                break;
            end
            if (weight_address_1 < wmin) wmin = weight_address_1;
            if (weight_address_2 > wmax) wmax = weight_address_2;
            if (pixel_address_2 > pmax)  pmax = pixel_address_2;
            if (repulse && cycles == 200) begin
                begin_mult = 1'b1;
                row_select = 4'd3;
            end else begin
                begin_mult = 1'b0;
            end
            step();
            cycles++;
        end
        begin_mult = 1'b0;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(cycles), 64'd392);
        check({tag, " result"}, 64'(row_result), 64'(exp_res));
        check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
        check({tag, " w_ena"}, 64'(w_result_ena), 64'd1);
        check({tag, " wmin"}, 64'(wmin), 64'(base));
        check({tag, " wmax"}, 64'(wmax), 64'(base + 13'd783));
        check({tag, " pmax"}, 64'(pmax), 64'd783);
        step();
        check({tag, " done_pulse"}, 64'(done_row), 64'd0);
        check({tag, " idle_waddr"}, 64'({weight_address_1, weight_address_2}),
              64'({base, base + 13'd1}));
        check({tag, " idle_paddr"}, 64'({pixel_address_1, pixel_address_2}), 64'({10'd0, 10'd1}));
        check({tag, " held_result"}, 64'(row_result), 64'(exp_res));
    endtask

    // Waits a fixed span and counts any done_row pulse as an error.
    task automatic expect_quiet(input int n, input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (done_row || w_result_ena) pulses++;
        end
        check({tag, " no_done"}, 64'(pulses), 64'd0);
    endtask

    function automatic logic [15:0] addr_model(input logic [3:0] r);
        int sum;
        sum = 0;
        for (int i = 0; i < 784; i++)
            sum += (i % 3) * ((int'(r) * 784 + i) % 41);
        return 16'(sum);
    endfunction

    vec_t vecs[7];

    initial begin
        vecs[0] = '{row: 4'd0, p1: 8'd1,   p2: 8'd1, w1: 16'd1,     w2: 16'd1,     exp_res: 16'd784,   exp_ovf: 1'b0};
        vecs[1] = '{row: 4'd1, p1: 8'd1,   p2: 8'd1, w1: 16'd1,     w2: 16'd0,     exp_res: 16'd392,   exp_ovf: 1'b0};
        vecs[2] = '{row: 4'd2, p1: 8'd1,   p2: 8'd1, w1: 16'd168,   w2: 16'd0,     exp_res: 16'hFFFF,  exp_ovf: 1'b1};
        vecs[3] = '{row: 4'd5, p1: 8'd1,   p2: 8'd1, w1: 16'd167,   w2: 16'd0,     exp_res: 16'd65464, exp_ovf: 1'b0};
        vecs[4] = '{row: 4'd9, p1: 8'd255, p2: 8'd255, w1: 16'd65535, w2: 16'd65535, exp_res: 16'hFFFF, exp_ovf: 1'b1};
        vecs[5] = '{row: 4'd3, p1: 8'd2,   p2: 8'd2, w1: 16'd3,     w2: 16'd5,     exp_res: 16'd6272,  exp_ovf: 1'b0};
        vecs[6] = '{row: 4'd4, p1: 8'd0,   p2: 8'd3, w1: 16'd999,   w2: 16'd7,     exp_res: 16'd8232,  exp_ovf: 1'b0};

        n_rst = 1'b1; begin_mult = 1'b0; row_select = 4'd0;
        p1c = 8'd0; p2c = 8'd0; w1c = 16'd0; w2c = 16'd0;
        step();
        step();
        check("reset result", 64'(row_result), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset done", 64'({done_row, w_result_ena}), 64'd0);
        check("reset addr", 64'({pixel_address_1, pixel_address_2, weight_address_1, weight_address_2}),
              64'({10'd0, 10'd1, 13'd0, 13'd1}));
        n_rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            p1c = vecs[i].p1; p2c = vecs[i].p2; w1c = vecs[i].w1; w2c = vecs[i].w2;
            run_row(vecs[i].row, vecs[i].exp_res, vecs[i].exp_ovf, 1'b0, $sformatf("vec%0d", i));
        end

        addr_mode = 1'b1;
        run_row(4'd6, addr_model(4'd6), 1'b0, 1'b0, "addr_row6");
        run_row(4'd8, addr_model(4'd8), 1'b0, 1'b0, "addr_row8");
        addr_mode = 1'b0;

        // Begin with an out-of-range row in IDLE is ignored and does not move the row.
        row_select = 4'd12;
        begin_mult = 1'b1;
        step();
        begin_mult = 1'b0;
        check("bad_row waddr", 64'(weight_address_1), 64'(13'd6272));
        expect_quiet(400, "bad_row");

        // Mid-row re-pulse with a different row has no effect.
        p1c = 8'd1; p2c = 8'd1; w1c = 16'd1; w2c = 16'd1;
        run_row(4'd7, 16'd784, 1'b0, 1'b1, "repulse");
        expect_quiet(10, "repulse_after");

        // Reset 100 cycles into a row aborts it.
        p1c = 8'd255; p2c = 8'd255; w1c = 16'd10; w2c = 16'd10;
        row_select = 4'd2;
        begin_mult = 1'b1;
        step();
        begin_mult = 1'b0;
        for (int i = 0; i < 100; i++) step();
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        check("abort result", 64'(row_result), 64'd0);
        check("abort overflow", 64'(overflow), 64'd0);
        check("abort done", 64'({done_row, w_result_ena}), 64'd0);
        check("abort addr", 64'({pixel_address_1, pixel_address_2, weight_address_1, weight_address_2}),
              64'({10'd0, 10'd1, 13'd0, 13'd1}));
        expect_quiet(400, "abort");
        // 392 * (255*10 + 255*10) = 1999200 saturates.
        run_row(4'd2, 16'hFFFF, 1'b1, 1'b0, "after_abort");
        p1c = 8'd1; p2c = 8'd1; w1c = 16'd2; w2c = 16'd3;
        run_row(4'd0, 16'd1960, 1'b0, 1'b0, "final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
